// File: rtl/cic_pkg.sv
// Shared constants, source-select type and helper functions for the CIC interpolator
// and its decimating counterpart.
package cic_pkg;

  localparam int N_STAGES  = 4;
  localparam int DIN_W     = 16;
  localparam int DOUT_W    = 12;
  localparam int RATE_W    = 13;
  localparam int RMAX_LOG2 = 12;
  localparam int ACC_W     = DIN_W + N_STAGES * RMAX_LOG2 - RMAX_LOG2;
  localparam int RATE_MIN  = 4;
  localparam int RATE_MAX  = 4096;
  localparam int SHIFT_W   = 6;

  typedef enum logic [1:0] {
    SRC_HOLD,
    SRC_BYPASS,
    SRC_ZERO
  } src_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i <= RATE_W; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [SHIFT_W-1:0] calc_shift(input logic [RATE_W-1:0] r);
    return SHIFT_W'((N_STAGES - 1) * clog2(int'(r)) + (DIN_W - DOUT_W));
  endfunction

  function automatic logic [DOUT_W-1:0] sat_dout(input logic signed [ACC_W-1:0] v);
    if ((&v[ACC_W-1:DOUT_W-1]) || !(|v[ACC_W-1:DOUT_W-1])) return v[DOUT_W-1:0];
    return v[ACC_W-1] ? {1'b1, {(DOUT_W-1){1'b0}}} : {1'b0, {(DOUT_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/cic_interp_integrator_chain.sv
// Cascade of N registered accumulators; every stage advances on the shared enable
// and wraps modulo 2^ACC_W.
module cic_integrator_chain
  import cic_pkg::*;
(
  input  logic                    dspclk,
  input  logic                    reset,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic signed [ACC_W-1:0] i_din,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [ACC_W-1:0] r_acc [N_STAGES];

  always_ff @(posedge dspclk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_STAGES; k++) r_acc[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < N_STAGES; k++) r_acc[k] <= '0;
    end else if (i_en) begin
      r_acc[0] <= r_acc[0] + i_din;
      for (int k = 1; k < N_STAGES; k++) r_acc[k] <= r_acc[k] + r_acc[k-1];
    end
  end

  assign o_acc = r_acc[N_STAGES-1];

endmodule

// File: rtl/cic_interp.sv
// Programmable-rate CIC interpolator: one-deep input holding register, low-rate comb
// chain, zero-stuffing into the integrator chain, scaled and saturated DAC output.
module cic_interp
  import cic_pkg::*;
(
  input  logic              dspclk,
  input  logic              reset,
  input  logic              sclr,
  input  logic              rate_we,
  input  logic [RATE_W-1:0] rate,
  input  logic [DIN_W-1:0]  din,
  input  logic              nd,
  output logic              rfd,
  input  logic              out_ce,
  output logic [DOUT_W-1:0] dout,
  output logic              rdy,
  output logic              underrun
);

  logic [RATE_W-1:0]       r_reff;
  logic [SHIFT_W-1:0]      r_shift;
  logic [RMAX_LOG2-1:0]    r_phase;
  logic                    r_full;
  logic [DIN_W-1:0]        r_hold;
  logic                    r_underrun;
  logic signed [ACC_W-1:0] r_dly [N_STAGES];
  logic [DOUT_W-1:0]       r_dout;
  logic                    r_rdy;

  logic                    w_clr;
  logic                    w_consume;
  logic                    w_phase_wrap;
  logic [RATE_W-1:0]       w_rate_clamped;
  src_e                    w_src;
  logic [DIN_W-1:0]        w_x_raw;
  logic signed [ACC_W-1:0] w_cin [N_STAGES];
  logic signed [ACC_W-1:0] w_cout;
  logic signed [ACC_W-1:0] w_integ_in;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_scaled;

  assign w_clr        = sclr | rate_we;
  assign w_consume    = out_ce & (r_phase == '0);
  assign w_phase_wrap = ({1'b0, r_phase} == (r_reff - RATE_W'(1)));

  always_comb begin
    w_rate_clamped = rate;
    if (rate < RATE_W'(RATE_MIN))      w_rate_clamped = RATE_W'(RATE_MIN);
    else if (rate > RATE_W'(RATE_MAX)) w_rate_clamped = RATE_W'(RATE_MAX);
  end

  // Source priority at a consume: held sample, then same-cycle bypass, else a zero.
  always_comb begin
    logic signed [ACC_W-1:0] v;
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    w_src   = SRC_ZERO;
    w_x_raw = '0;
    if (r_full) begin
      w_src   = SRC_HOLD;
      w_x_raw = r_hold;
    end else if (nd) begin
      w_src   = SRC_BYPASS;
      w_x_raw = din;
    end
    v = {{(ACC_W-DIN_W){w_x_raw[DIN_W-1]}}, w_x_raw};
    for (int k = 0; k < N_STAGES; k++) begin
      w_cin[k] = v;
      v        = v - r_dly[k];
    end
    w_cout = v;
  end

  assign w_integ_in = w_consume ? w_cout : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge dspclk or posedge reset) begin
    if (reset) begin
      r_reff  <= RATE_W'(RATE_MIN);
      r_shift <= calc_shift(RATE_W'(RATE_MIN));
    end else if (rate_we) begin
      r_reff  <= w_rate_clamped;
      r_shift <= calc_shift(w_rate_clamped);
    end
  end

  always_ff @(posedge dspclk or posedge reset) begin
    if (reset) begin
      r_phase    <= '0;
      r_full     <= 1'b0;
      r_hold     <= '0;
      r_underrun <= 1'b0;
    end else if (w_clr) begin
      r_phase    <= '0;
      r_full     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (out_ce) r_phase <= w_phase_wrap ? '0 : r_phase + 1'b1;
      if (w_consume) begin
        if (w_src == SRC_HOLD) r_full     <= 1'b0;
        if (w_src == SRC_ZERO) r_underrun <= 1'b1;
      end else if (nd && !r_full) begin
        r_hold <= din;
        r_full <= 1'b1;
      end
    end
  end

  // NOTE: the comb delay array is reset and cleared because sclr must restart from silence.
  always_ff @(posedge dspclk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_STAGES; k++) r_dly[k] <= '0;
    end else if (w_clr) begin
      for (int k = 0; k < N_STAGES; k++) r_dly[k] <= '0;
    end else if (w_consume) begin
      for (int k = 0; k < N_STAGES; k++) r_dly[k] <= w_cin[k];
    end
  end

  cic_integrator_chain u_integ (
    .dspclk (dspclk),
    .reset  (reset),
    .i_en   (out_ce & ~w_clr),
    .i_clr  (w_clr),
    .i_din  (w_integ_in),
    .o_acc  (w_acc)
  );

  assign w_scaled = w_acc >>> r_shift;

  always_ff @(posedge dspclk or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
      r_rdy  <= 1'b0;
    end else if (w_clr) begin
      r_dout <= '0;
      r_rdy  <= 1'b0;
    end else begin
      r_rdy <= out_ce;
      if (out_ce) r_dout <= sat_dout(w_scaled);
    end
  end

  assign rfd      = ~r_full;
  assign dout     = r_dout;
  assign rdy      = r_rdy;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_cic_interp.sv
// Self-checking bench for cic_interp: a spec-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_cic_interp;

  localparam int N = 4;

  logic        dspclk = 1'b0;
  logic        reset  = 1'b0;
  logic        sclr, rate_we, nd, out_ce;
  logic [12:0] rate;
  logic [15:0] din;
  logic        rfd, rdy, underrun;
  logic [11:0] dout;

  int n_checks = 0;
  int n_errors = 0;
  int feed     = 0;  // 0 none, 1 nd held high, 2 nd only on consume cycles
  int ce_per   = 4;

  cic_interp dut (
    .dspclk   (dspclk),
    .reset    (reset),
    .sclr     (sclr),
    .rate_we  (rate_we),
    .rate     (rate),
    .din      (din),
    .nd       (nd),
    .rfd      (rfd),
    .out_ce   (out_ce),
    .dout     (dout),
    .rdy      (rdy),
    .underrun (underrun)
  );

  always #5 dspclk = ~dspclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_reff;
  int          m_shift, m_phase;
  bit          m_full, m_underrun, m_rdy;
  logic [15:0] m_hold;
  logic [11:0] m_dout;
  longint      m_x   [N+1];
  longint      m_int [N];

  function automatic longint wrap_acc(input longint v);
    return (v <<< 12) >>> 12;
  endfunction

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic int shift_of(input int unsigned r);
    return (N - 1) * $clog2(r) + 4;
  endfunction

  task model_clear(input bit por);
    m_phase = 0; m_full = 0; m_underrun = 0; m_rdy = 0; m_dout = '0;
    for (int k = 0; k <= N; k++) m_x[k] = 0;
    for (int k = 0; k < N; k++) m_int[k] = 0;
    if (por) begin
      m_reff  = 4;
      m_shift = shift_of(4);
    end
  endtask

  always @(posedge dspclk or posedge reset) begin
    if (reset) begin
      model_clear(1'b1);
    end else if (sclr || rate_we) begin
      if (rate_we) begin
        m_reff  = (rate < 4) ? 4 : (rate > 4096) ? 4096 : int'(rate);
        m_shift = shift_of(m_reff);
      end
      model_clear(1'b0);
    end else begin
      longint      u, y;
      bit          consume;
      logic [15:0] x;
      m_rdy   = out_ce;
      consume = out_ce && (m_phase == 0);
      if (out_ce) begin
        y = m_int[N-1] >>> m_shift;
        if (y > 2047)  y = 2047;
        if (y < -2048) y = -2048;
        m_dout = y[11:0];
      end
      u = 0;
      if (consume) begin
        if (m_full) begin
          x = m_hold; m_full = 0;
        end else if (nd) begin
          x = din;
        end else begin
          x = '0; m_underrun = 1;
        end
        for (int k = N; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = longint'(signed'(x));
        // N-th difference of the low-rate input stream.
        for (int k = 0; k <= N; k++) u += ((k % 2) ? -1 : 1) * binom(N, k) * m_x[k];
      end else if (nd && !m_full) begin
        m_hold = din; m_full = 1;
      end
      if (out_ce) begin
        for (int k = N - 1; k > 0; k--) m_int[k] = wrap_acc(m_int[k] + m_int[k-1]);
        m_int[0] = wrap_acc(m_int[0] + u);
        m_phase  = (m_phase + 1 == int'(m_reff)) ? 0 : m_phase + 1;
      end
    end
  end

  always @(negedge dspclk) begin
    check("rfd", rfd, !m_full);
    check("rdy", rdy, m_rdy);
    check("underrun", underrun, m_underrun);
    check("dout", dout, m_dout);
  end

  // ---------------- stimulus ----------------
  initial begin
    int ce_cnt;
    ce_cnt = 0;
    forever begin
      @(posedge dspclk); #1;
      if (ce_cnt >= ce_per - 1) ce_cnt = 0; else ce_cnt++;
      out_ce = (ce_cnt == 0);
      case (feed)
        1:       nd = 1'b1;
        2:       nd = out_ce && (m_phase == 0) && !m_full;
        default: nd = 1'b0;
      endcase
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge dspclk);
  endtask

  task automatic pulse_sclr();
    @(posedge dspclk); #1; sclr = 1'b1;
    @(posedge dspclk); #1; sclr = 1'b0;
  endtask

  task automatic load_rate(input logic [12:0] r);
    @(posedge dspclk); #1; rate = r; rate_we = 1'b1;
    @(posedge dspclk); #1; rate_we = 1'b0;
  endtask

  task automatic expect_rdy(input string name, input logic [11:0] exp);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge dspclk);
      if (rdy) seen = 1;
    end
    if (!seen) check({name, "_rdy_timeout"}, 0, 1);
    else       check(name, dout, exp);
  endtask

  task automatic rdy_period(input string name, input int exp);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge dspclk);
      n++;
      if (rdy) seen = 1;
    end
    check(name, n, exp);
  endtask

  task automatic rfd_period(input string name, input int exp);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge dspclk);
      if (rfd) seen = 1;
    end
    if (!seen) begin
      check({name, "_rfd_timeout"}, 0, 1);
    end else begin
      seen = 0;
      for (int i = 0; i < 6000 && !seen; i++) begin
        @(negedge dspclk);
        n++;
        if (rfd) seen = 1;
      end
      check(name, n, exp);
    end
  endtask

  task automatic wait_underrun(input string name);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge dspclk);
      if (underrun) seen = 1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    int cnt;
    sclr = 0; rate_we = 0; rate = '0; din = 16'h0100; nd = 0; out_ce = 0;
    #1 reset = 1'b1;
    #1;
    check("por_dout", dout, 12'h000);
    check("por_rdy", rdy, 0);
    check("por_rfd", rfd, 1);
    check("por_underrun", underrun, 0);
    wait_cycles(3); #3 reset = 1'b0;

    // DC at the reset rate of 4, out_ce every 4 clocks.
    feed = 1;
    wait_cycles(200);
    expect_rdy("dc4_dout", 12'h010);
    rdy_period("dc4_rdy_period", 4);
    check("dc4_underrun", underrun, 0);

    // Handshake with nd held high: one accept per R out_ce strobes.
    ce_per = 1;
    wait_cycles(20);
    rfd_period("hs_accept_period", 4);

    // Bypass: nd only when an empty buffer meets a consume.
    feed = 2;
    pulse_sclr();
    wait_cycles(100);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge dspclk);
      if (rfd) cnt++;
    end
    check("bypass_rfd_high", cnt, 20);
    expect_rdy("bypass_dout", 12'h010);
    check("bypass_underrun", underrun, 0);

    // Underrun: starve a steady stream.
    feed = 1; ce_per = 4;
    pulse_sclr();
    wait_cycles(200);
    expect_rdy("ur_pre_dout", 12'h010);
    feed = 0;
    wait_underrun("ur_set");
    wait_cycles(200);
    expect_rdy("ur_decay_dout", 12'h000);
    check("ur_sticky", underrun, 1);
    pulse_sclr();
    @(negedge dspclk);
    check("ur_sclr_clear", underrun, 0);

    // Negative full scale.
    din = 16'h8000; feed = 1;
    pulse_sclr();
    wait_cycles(200);
    expect_rdy("negfs_dout", 12'h800);

    // Rate change 4 -> 8 mid-stream.
    din = 16'h0100;
    pulse_sclr();
    wait_cycles(200);
    expect_rdy("r4_dout", 12'h010);
    load_rate(13'd8);
    expect_rdy("r8_first_dout", 12'h000);
    wait_cycles(400);
    expect_rdy("r8_dout", 12'h010);

    // Non-power-of-two rate: 256*125 >> 13 = 3.
    load_rate(13'd5);
    wait_cycles(400);
    expect_rdy("r5_dout", 12'h003);

    // Async reset between edges while starved at rate 5.
    feed = 0;
    wait_underrun("r5_underrun");
    @(posedge dspclk); #3 reset = 1'b1;
    #1;
    check("areset_dout", dout, 12'h000);
    check("areset_rdy", rdy, 0);
    check("areset_underrun", underrun, 0);
    check("areset_rfd", rfd, 1);
    wait_cycles(3); #3 reset = 1'b0;
    feed = 1;
    wait_cycles(200);
    expect_rdy("post_reset_dout", 12'h010);

    // Rate clamping.
    ce_per = 1;
    load_rate(13'd2);
    wait_cycles(20);
    rfd_period("clamp_low_period", 4);
    load_rate(13'd5000);
    wait_cycles(10);
    rfd_period("clamp_high_period", 4096);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cic_interp.md
Name: cic_interp

Overview:
- Programmable-rate CIC interpolator for the TX DSP path; the counterpart of the RX cic_decim.
- Accepts low-rate 16-bit samples through an rfd/nd handshake and zero-stuffs them by R.
- Filters through N comb and N integrator stages and emits 12-bit samples toward the DAC, one per out_ce strobe (for example 32 MHz strobes on the 128 MHz dspclk).

Parameters:
- N_STAGES, 4, number of comb stages and number of integrator stages (differential delay M=1).
- DIN_W, 16, input sample width, two's complement.
- DOUT_W, 12, output sample width, two's complement.
- RATE_W, 13, width of the rate port.
- RMAX_LOG2, 12, log2 of the maximum rate (4096).
- ACC_W, DIN_W+N_STAGES*RMAX_LOG2-RMAX_LOG2 (52), internal datapath width.

Ports:
- dspclk  in  1  DSP clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sclr  in  1  synchronous clear of the datapath, phase counter and underrun flag; the rate register is kept.
- rate_we  in  1  one-cycle strobe that loads rate.
- rate  in  RATE_W  interpolation factor R.
- din  in  DIN_W  input sample.
- nd  in  1  new data; din is accepted when nd&rfd.
- rfd  out  1  ready for data.
- out_ce  in  1  output-rate strobe; each strobe produces exactly one output.
- dout  out  DOUT_W  output sample.
- rdy  out  1  one-cycle pulse; dout is new this cycle.
- underrun  out  1  sticky flag: a zero was injected because no input was available.

Behaviour:
- Reset values (async): dout=0, rdy=0, rfd=1, underrun=0, all comb/integrator registers 0, phase=0, R_eff=4, shift=10.
- Rate load:
  - On rate_we, R_eff = clamp(rate, 4, 4096).
  - shift = (N_STAGES-1)*clog2(R_eff) + (DIN_W-DOUT_W); registered.
  - rate_we also performs the sclr action in the same cycle.
  - rate_we and sclr together: both take effect.
- Input holding register (one deep):
  - rfd = ~full.
  - nd&rfd: load din, set full.
  - nd while rfd=0 is ignored.
- Phase counter:
  - Advances on out_ce, counting 0..R_eff-1 and wrapping to 0.
  - An out_ce with phase==0 is a consume event.
- Consume event, one case applies:
  - full: the held sample enters comb stage 1 and full clears. rfd rises the next cycle.
  - empty and nd in the same cycle: din bypasses the holding register into the comb and full stays 0.
  - empty and no nd: zero enters the comb and underrun sets. underrun clears only on reset, sclr or rate_we.
- Comb stages:
  - Update only on consume events: c_k = x_k - x_k_delayed.
  - Input sign-extended to ACC_W.
- Zero-stuff: integrator-1 input = comb output on a consume event, else 0.
- Integrators:
  - All N advance on every out_ce, cascaded and registered.
  - Modulo-2^ACC_W wrap is intended; no overflow detection.
- Output:
  - On each out_ce, out_reg = saturate_DOUT_W(acc_N >>> shift), an arithmetic shift (truncation toward -inf).
  - dout and rdy=1 appear the cycle after out_ce; rdy is low otherwise.
  - out_ce on consecutive cycles is legal and must give consecutive rdy pulses.
- DC gain: R_eff^(N-1) / 2^shift.
- Latency: the first non-zero output appears within 2*N_STAGES+1 out_ce strobes after the first consume.
- Reset or sclr mid-stream: the next output is 0, then the block refills normally. The holding register is emptied (rfd=1).

Decomposition:
- Package cic_pkg holds:
  - N_STAGES, DIN_W, DOUT_W, RATE_W, RMAX_LOG2 and ACC_W.
  - RATE_MIN=4 and RATE_MAX=4096.
  - A clog2 function and the shift-calculation function.
  - Saturate is shared with cic_decim.
- One sub-module, cic_integrator_chain: N registered accumulators with a common enable and clear, instantiated with out_ce.
- Comb chain, holding register, phase counter and output stay in cic_interp.

Test Plan:
- Steady DC, rate=4: din=16'h0100 offered whenever rfd, out_ce every 4 dspclk -> after fill, dout=12'h010 on every rdy; rdy period 4 dspclk; underrun=0.
- Non-power-of-two, rate=5: din=16'h0100 -> steady dout=12'h003 (256*125>>13). Negative full scale at rate=4, din=16'h8000 -> dout=12'h800, no wrap.
- Handshake: nd held high continuously at rate=4 -> exactly one accept per 4 out_ce; rfd low while full. Also a bypass case: an empty buffer with nd coinciding with a consume is accepted and rfd stays 1.
- Underrun: stop nd after steady state -> underrun=1 at the first starved consume; dout decays to 0 and stays 0. sclr -> underrun=0.
- Rate change mid-stream, 4 -> 8 via rate_we: pipeline cleared, next dout=0, then reconverges to 12'h010 (gain 512, shift 13). rate=2 and rate=5000 -> behave as 4 and 4096.
- Async reset asserted between dspclk edges mid-stream: dout, rdy and underrun go to 0 immediately, rfd=1, R_eff=4. After release, the DC test again yields 12'h010.
